// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 valid/ready stream multiplexer with a registered
// output stage. Arbitration is either a fixed channel select or a
// round-robin scan that starts at a rotating pointer.
//
// Handshake: a word moves across an interface in any cycle where its valid
// and ready are both 1. Valid, once raised, is never taken back before the
// word moves, and the data beside it stays stable. Ready may depend
// combinationally on the other side's valid. The output register may take a
// new word whenever it is empty or being drained in the same cycle
// (w_load_en). Input readiness therefore depends combinationally on
// out_ready. out_data and out_valid depend on out_ready only through the
// register.
module stream_mux_rr #(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int SW    = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SW-1:0]        sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SW-1:0]        out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Advances a channel index by one and wraps it at NCH. NCH need not be a
  // power of two.
  function automatic logic [SW-1:0] wrap_inc(input logic [SW-1:0] idx);
    if (int'(idx) + 1 >= NCH) return '0;
    return SW'(int'(idx) + 1);
  endfunction

  logic [SW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_data;
  logic [SW-1:0]    r_ch;
  logic             r_valid;

  logic             w_load_en;
  logic             w_sel_ok;
  logic             w_rr_found;
  logic [SW-1:0]    w_rr_grant;
  logic [SW-1:0]    w_scan_idx;
  logic [SW-1:0]    w_grant;
  logic             w_grant_ok;
  logic             w_xfer;
  logic [WIDTH-1:0] w_word;

  assign w_load_en  = !r_valid || out_ready;
  assign w_sel_ok   = (int'(sel) < NCH);
  assign w_grant    = mode ? w_rr_grant : sel;
  assign w_grant_ok = mode ? w_rr_found : w_sel_ok;

  // Round-robin scan: the first valid channel at or after r_ptr, wrapping.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_grant = '0;
    w_scan_idx = r_ptr;
    for (int k = 0; k < NCH; k++) begin
      if (!w_rr_found && in_valid[w_scan_idx]) begin
        w_rr_found = 1'b1;
        w_rr_grant = w_scan_idx;
      end
      w_scan_idx = wrap_inc(w_scan_idx);
    end
  end

  // One-hot ready to the granted channel. It is suppressed during reset and
  // while the output register cannot load.
  always_comb begin
    in_ready = '0;
    if (!rst && w_load_en && w_grant_ok) begin
      in_ready[w_grant] = 1'b1;
    end
  end

  assign w_xfer = |(in_ready & in_valid);

  // Data mux for the granted channel. This form avoids an out-of-range
  // part-select when sel is not a valid channel.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < NCH; i++) begin
      if (SW'(i) == w_grant) w_word = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register and round-robin pointer. The pointer moves only on a
  // round-robin transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_ptr   <= '0;
    end else if (w_load_en) begin
      if (w_xfer) begin
        r_valid <= 1'b1;
        r_data  <= w_word;
        r_ch    <= w_grant;
        if (mode) r_ptr <= wrap_inc(w_grant);
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_ch    = r_ch;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenarios plus randomized traffic. Each
// cycle is checked against a behavioural model and an expected-word queue.
module tb_stream_mux_rr;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SW    = 2;

  // ---------------- clock / reset / signals ----------------
  logic                 clk = 1'b0;
  logic                 rst;
  logic                 mode;
  logic [SW-1:0]        sel;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SW-1:0]        out_ch;
  logic                 out_valid;
  logic                 out_ready;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  // ---------------- reference model state ----------------
  int                   m_ptr;
  logic                 m_valid;
  logic [WIDTH-1:0]     m_data;
  int                   m_ch;
  logic [SW+WIDTH-1:0]  exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic rand_data();
    for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 255));
  endtask

  task automatic drive(input logic r, input logic md, input int s,
                       input logic [NCH-1:0] v, input logic ordy);
    rst = r; mode = md; sel = SW'(s); in_valid = v; out_ready = ordy;
    rand_data();
  endtask

  // One clock: check the current cycle against the model at the negedge,
  // then advance the model across the rising edge. Returns 1 time unit after
  // the edge.
  task automatic run_cycle();
    logic [NCH-1:0]      exp_ready;
    logic                load;
    logic                found;
    int                  g;
    int                  c;
    int                  n_ptr;
    logic                n_valid;
    logic [WIDTH-1:0]    n_data;
    int                  n_ch;
    logic [SW+WIDTH-1:0] item;
    @(negedge clk);
    load = !m_valid || out_ready;
    exp_ready = '0;
    g = -1;
    found = 1'b0;
    if (!rst && load) begin
      if (mode == 1'b0) begin
        if (int'(sel) < NCH) begin
          g = int'(sel);
          exp_ready[g] = 1'b1;
        end
      end else begin
        for (int k = 0; k < NCH; k++) begin
          c = (m_ptr + k) % NCH;
          if (!found && in_valid[c]) begin
            found = 1'b1;
            g = c;
            exp_ready[c] = 1'b1;
          end
        end
      end
    end
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_ch", 32'(out_ch), 32'(m_ch));
    if (!rst && m_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        item = exp_q.pop_front();
        check("sb_word", 32'({out_ch, out_data}), 32'(item));
      end
    end
    n_ptr = m_ptr; n_valid = m_valid; n_data = m_data; n_ch = m_ch;
    if (rst) begin
      n_ptr = 0; n_valid = 1'b0; n_data = '0; n_ch = 0;
      exp_q.delete();
    end else if (load) begin
      if (g >= 0 && in_valid[g]) begin
        n_data  = in_data[g*WIDTH +: WIDTH];
        n_ch    = g;
        n_valid = 1'b1;
        exp_q.push_back({SW'(g), n_data});
        if (mode) n_ptr = (g + 1) % NCH;
      end else begin
        n_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_ptr = n_ptr; m_valid = n_valid; m_data = n_data; m_ch = n_ch;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] held_data;
    logic [SW-1:0]    held_ch;
    m_ptr = 0; m_valid = 1'b0; m_data = '0; m_ch = 0;
    drive(1'b1, 1'b1, 0, 4'b1111, 1'b1);
    @(posedge clk); #1;

    // Reset: valid channels must not be consumed.
    run_cycle();
    run_cycle();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);

    // Fairness: all channels valid, so the grant order is 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 0, 4'b1111, 1'b1);
      run_cycle();
      check("fair_ch", 32'(out_ch), 32'(k % NCH));
      check("fair_valid", 32'(out_valid), 32'd1);
    end

    // Skip: pointer is back at 0 after reset.
    drive(1'b1, 1'b1, 0, 4'b0000, 1'b1);
    run_cycle();
    drive(1'b0, 1'b1, 0, 4'b0100, 1'b1);
    run_cycle();
    check("skip_ch2", 32'(out_ch), 32'd2);
    drive(1'b0, 1'b1, 0, 4'b1001, 1'b1);
    run_cycle();
    check("skip_ch3", 32'(out_ch), 32'd3);
    drive(1'b0, 1'b1, 0, 4'b1001, 1'b1);
    run_cycle();
    check("skip_ch0", 32'(out_ch), 32'd0);

    // Backpressure: hold for 3 cycles, then load in the release cycle.
    held_data = out_data;
    held_ch   = out_ch;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 0, 4'b1111, 1'b0);
      run_cycle();
      check("bp_data", 32'(out_data), 32'(held_data));
      check("bp_ch", 32'(out_ch), 32'(held_ch));
    end
    drive(1'b0, 1'b1, 0, 4'b1111, 1'b1);
    #1;
    check("bp_release_ready", 32'(in_ready), 32'b0010);
    run_cycle();
    check("bp_next_ch", 32'(out_ch), 32'd1);

    // Fixed select: the pointer (now 2) must not move in fixed mode.
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 2, 4'b1111, 1'b1);
      in_data[2*WIDTH +: WIDTH] = 8'hA5;
      #1;
      check("fix_ready", 32'(in_ready), 32'b0100);
      run_cycle();
      check("fix_data", 32'(out_data), 32'hA5);
      check("fix_ch", 32'(out_ch), 32'd2);
    end
    drive(1'b0, 1'b1, 0, 4'b1111, 1'b1);
    run_cycle();
    check("fix_ptr_hold", 32'(out_ch), 32'd2);

    // Reset mid-stream discards the word; the grant order restarts at 0.
    drive(1'b1, 1'b1, 0, 4'b1111, 1'b0);
    run_cycle();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'd0);
    drive(1'b0, 1'b1, 0, 4'b1111, 1'b1);
    run_cycle();
    check("mid_rst_restart", 32'(out_ch), 32'd0);

    // Idle: the output drains and out_data holds its last value.
    held_data = out_data;
    drive(1'b0, 1'b1, 0, 4'b0000, 1'b1);
    run_cycle();
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_data", 32'(out_data), 32'(held_data));

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, NCH - 1)), NCH'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0));
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel; legal range is 1 or more.
REQ-002 Parameter NCH, default 4, number of input channels; legal range is 2 to 16.
REQ-003 Localparam SW = clog2(NCH), width of select and channel-index fields.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mode  input  1  arbitration mode: 0 = fixed select, 1 = round-robin.
REQ-007 sel  input  SW  channel index used when mode=0.
REQ-008 in_data  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  NCH  per-channel valid.
REQ-010 in_ready  output  NCH  per-channel ready; combinational.
REQ-011 out_data  output  WIDTH  registered data.
REQ-012 out_ch  output  SW  registered index of the source channel of out_data.
REQ-013 out_valid  output  1  registered valid.
REQ-014 out_ready  input  1  downstream ready.

Function
REQ-015 Transfer rule: a channel transfers when in_valid[i] and in_ready[i] are both 1 in the same cycle; the output transfers when out_valid and out_ready are both 1 in the same cycle.
REQ-016 load_en = !out_valid || out_ready; the output register SHALL accept new data only when load_en=1.
REQ-017 At most one in_ready bit SHALL be 1 in any cycle, and no in_ready bit SHALL be 1 while load_en=0.
REQ-018 Fixed mode (mode=0): in_ready[sel] = load_en; all other in_ready bits are 0.
REQ-019 Fixed mode, sel >= NCH: all in_ready bits are 0 and no load occurs.
REQ-020 Round-robin mode (mode=1): grant g is the first i with in_valid[i]=1, scanning cyclically from ptr through ptr+NCH-1 mod NCH.
REQ-021 Round-robin mode: in_ready[g] = load_en; if no in_valid bit is set, no bit of in_ready is 1.
REQ-022 Pointer update: ptr (SW bits) SHALL become (g+1) mod NCH only on a round-robin transfer; it SHALL hold otherwise, including in every fixed-mode cycle.
REQ-023 On any input transfer from channel c, the next out_data = in_data[c], out_ch = c, and out_valid = 1 (latency 1 cycle).
REQ-024 When load_en=1 and no input transfer occurs, out_valid SHALL become 0; out_data and out_ch SHALL hold their values.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_ch and out_valid SHALL hold stable.
REQ-026 Throughput: one word per cycle SHALL be sustained while out_ready=1 and a grantable channel is valid.
REQ-027 A mode or sel change SHALL take effect in the same cycle for the in_ready decision; data already registered is unaffected by the change.
REQ-028 No path SHALL exist from out_ready to out_data or to out_valid except through the register.
REQ-029 Simultaneous output drain and input load in one cycle SHALL replace the registered word with no bubble.

Reset
REQ-030 While rst=1 at a clock edge: out_valid=0, out_data=0, out_ch=0, ptr=0.
REQ-031 While rst=1, all in_ready bits SHALL be 0, and any in_valid asserted during reset SHALL NOT be consumed.
REQ-032 Reset asserted mid-transfer SHALL discard the registered word; the first grant after reset SHALL be decided from ptr=0.

Verification
REQ-033 RR fairness: NCH=4, mode=1, all in_valid=1111, out_ready=1 -> out_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-034 RR skip: in_valid=0100 then 1001, ptr=0 -> grants 2 then 3; next grant with in_valid=1001 is 0.
REQ-035 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data/out_ch stable and in_ready=0000; on out_ready=1 the next word loads in that same cycle.
REQ-036 Fixed mode: mode=0, sel=2, in_data channel 2=0xA5 and valid on all channels -> only in_ready[2]=1, out_data=0xA5, out_ch=2; ptr unchanged.
REQ-037 Reset mid-stream: rst=1 for one cycle while out_valid=1 -> out_valid=0 and out_data=0 the next cycle; RR grant order restarts at channel 0.
REQ-038 Idle: in_valid=0000, out_ready=1 -> out_valid falls to 0 after the last word drains; out_data holds its last value.
